// File: rtl/pedal_blip_conditioner.sv
// pedal_blip_conditioner
//   Cleans up the raw pedal-crank hall sensor for the cadence calculator.
//   The sensor is synchronised, debounced, and rising edges that arrive
//   faster than a human can pedal are rejected. Every accepted rising edge
//   produces a one-cycle strobe plus a stretched blip, and the blip-to-blip
//   period and a pedaling flag are reported for the assist logic.
//
//   reset_n is asserted asynchronously; its release is expected to be
//   synchronous to clk50M (provided by the upstream reset generator).
//
// Ports
//   clk50M        in   system clock
//   reset_n       in   asynchronous active-low reset
//   sensor_raw    in   raw hall sensor, asynchronous to clk50M
//   blips_out     out  clean blip, high PULSE_CYC cycles per accepted edge
//   blip_pulse    out  one-cycle strobe per accepted edge
//   period_out    out  cycles between the last two accepted edges (0 = stopped)
//   period_valid  out  one-cycle strobe when period_out updates
//   pedaling      out  high while edges keep arriving within TIMEOUT_CYC
//   glitch_cnt    out  saturating count of rejected (too-fast) edges
//
// Debounce FSM
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   LOW       | sensor settled low, waiting for a high level
//   RISE_CHK  | sensor went high, must stay high DEBOUNCE_CYC cycles
//   HIGH      | sensor settled high, waiting for a low level
//   FALL_CHK  | sensor went low, must stay low DEBOUNCE_CYC cycles

module pedal_blip_conditioner #(
  parameter int unsigned DEBOUNCE_CYC   = 50_000,
  parameter int unsigned MIN_PERIOD_CYC = 2_500_000,
  parameter int unsigned TIMEOUT_CYC    = 100_000_000,
  parameter int unsigned PULSE_CYC      = 1_000,
  parameter int unsigned PERIOD_W       = 27
) (
  input  logic                clk50M,
  input  logic                reset_n,
  input  logic                sensor_raw,
  output logic                blips_out,
  output logic                blip_pulse,
  output logic [PERIOD_W-1:0] period_out,
  output logic                period_valid,
  output logic                pedaling,
  output logic [7:0]          glitch_cnt
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int PUL_W = $clog2(PULSE_CYC + 1);

  localparam logic [DEB_W-1:0]    DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
  localparam logic [PUL_W-1:0]    PUL_LOAD  = PUL_W'(PULSE_CYC - 1);
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT_CYC);
  localparam logic [PERIOD_W-1:0] MIN_V     = PERIOD_W'(MIN_PERIOD_CYC);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_RISE_CHK,
    ST_HIGH,
    ST_FALL_CHK
  } state_t;

  state_t              r_state;
  logic                r_sync1;
  logic                r_sync2;
  logic [DEB_W-1:0]    r_deb_cnt;

  logic                r_blips;
  logic                r_blip_pulse;
  logic [PUL_W-1:0]    r_pulse_cnt;
  logic [PERIOD_W-1:0] r_since_last;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;
  logic                r_pedaling;
  logic [7:0]          r_glitch_cnt;

  logic                w_rise_evt;
  logic [PERIOD_W-1:0] w_since_inc;
  logic                w_accept;
  logic                w_timeout;

  // Synchroniser and debounce FSM.
  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= ST_LOW;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= sensor_raw;
      r_sync2 <= r_sync1;
      case (r_state)
        ST_LOW: begin
          if (r_sync2) begin
            r_state   <= ST_RISE_CHK;
            r_deb_cnt <= '0;
          end
        end
        ST_RISE_CHK: begin
          if (!r_sync2)                  r_state   <= ST_LOW;
          else if (r_deb_cnt == DEB_LAST) r_state   <= ST_HIGH;
          else                           r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
        ST_HIGH: begin
          if (!r_sync2) begin
            r_state   <= ST_FALL_CHK;
            r_deb_cnt <= '0;
          end
        end
        ST_FALL_CHK: begin
          if (r_sync2)                   r_state   <= ST_HIGH;
          else if (r_deb_cnt == DEB_LAST) r_state   <= ST_LOW;
          else                           r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
        default: r_state <= ST_LOW;
      endcase
    end
  end

  // The rise event is decoded in the same cycle the FSM commits to HIGH so
  // the accepted edge shows up on the outputs one cycle later.
  assign w_rise_evt = (r_state == ST_RISE_CHK) && r_sync2 && (r_deb_cnt == DEB_LAST);

  // Elapsed time including the current cycle; this is what a period ending
  // now measures, so edges N cycles apart report exactly N.
  assign w_since_inc = (r_since_last == TIMEOUT_V) ? TIMEOUT_V
                                                    : r_since_last + PERIOD_W'(1);
  assign w_accept    = w_rise_evt && (!r_pedaling || (w_since_inc >= MIN_V));
  assign w_timeout   = r_pedaling && (r_since_last == TIMEOUT_V);

  always_ff @(posedge clk50M or negedge reset_n) begin
    if (!reset_n) begin
      r_blips        <= 1'b0;
      r_blip_pulse   <= 1'b0;
      r_pulse_cnt    <= '0;
      r_since_last   <= TIMEOUT_V;
      r_period       <= '0;
      r_period_valid <= 1'b0;
      r_pedaling     <= 1'b0;
      r_glitch_cnt   <= '0;
    end else begin
      r_blip_pulse   <= 1'b0;
      r_period_valid <= 1'b0;
      r_since_last   <= w_since_inc;

      // An accepted edge takes priority over a coincident timeout.
      if (w_accept) begin
        r_blip_pulse <= 1'b1;
        r_since_last <= '0;
        if (r_pedaling) begin
          r_period       <= w_since_inc;
          r_period_valid <= 1'b1;
        end else begin
          r_pedaling <= 1'b1;
        end
      end else begin
        if (w_rise_evt && (r_glitch_cnt != 8'hFF))
          r_glitch_cnt <= r_glitch_cnt + 8'd1;
        if (w_timeout) begin
          r_pedaling     <= 1'b0;
          r_period       <= '0;
          r_period_valid <= 1'b1;
        end
      end

      // Stretcher: down-counter loaded on accept, blip drops at terminal count.
      if (w_accept) begin
        r_blips     <= 1'b1;
        r_pulse_cnt <= PUL_LOAD;
      end else if (r_blips) begin
        if (r_pulse_cnt == '0) r_blips     <= 1'b0;
        else                   r_pulse_cnt <= r_pulse_cnt - PUL_W'(1);
      end
    end
  end

  assign blips_out    = r_blips;
  assign blip_pulse   = r_blip_pulse;
  assign period_out   = r_period;
  assign period_valid = r_period_valid;
  assign pedaling     = r_pedaling;
  assign glitch_cnt   = r_glitch_cnt;

endmodule

// File: tb/tb_pedal_blip_conditioner.sv
module tb_pedal_blip_conditioner;

  localparam int PERIOD_W = 27;
  localparam int LAT      = 11;
  localparam int PULSE    = 4;

  logic                clk50M = 1'b0;
  logic                reset_n = 1'b0;
  logic                sensor_raw = 1'b0;
  logic                blips_out;
  logic                blip_pulse;
  logic [PERIOD_W-1:0] period_out;
  logic                period_valid;
  logic                pedaling;
  logic [7:0]          glitch_cnt;

  pedal_blip_conditioner #(
    .DEBOUNCE_CYC  (8),
    .MIN_PERIOD_CYC(100),
    .TIMEOUT_CYC   (1000),
    .PULSE_CYC     (PULSE),
    .PERIOD_W      (PERIOD_W)
  ) dut (
    .clk50M      (clk50M),
    .reset_n     (reset_n),
    .sensor_raw  (sensor_raw),
    .blips_out   (blips_out),
    .blip_pulse  (blip_pulse),
    .period_out  (period_out),
    .period_valid(period_valid),
    .pedaling    (pedaling),
    .glitch_cnt  (glitch_cnt)
  );

  always #5 clk50M = ~clk50M;

  int cyc = 0;
  always @(posedge clk50M) cyc = cyc + 1;

  typedef struct {
    int cyc;
    bit blip;
    bit pv;
    int per;
    bit ped;
    int g;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   run    = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".blips_out"},    blips_out,    0);
    chk({tag, ".blip_pulse"},   blip_pulse,   0);
    chk({tag, ".period_out"},   period_out,   0);
    chk({tag, ".period_valid"}, period_valid, 0);
    chk({tag, ".pedaling"},     pedaling,     0);
    chk({tag, ".glitch_cnt"},   glitch_cnt,   0);
  endtask

  // Raise the sensor for hi cycles; if an output event is expected, its
  // record is queued before the stimulus starts.
  task automatic rise(input int hi, input bit eb, input bit ep, input int eper,
                      input bit eped, input int eg, output int n);
    exp_t e;
    n = cyc;
    if (eb || ep) begin
      e = '{cyc: n + LAT, blip: eb, pv: ep, per: eper, ped: eped, g: eg};
      q.push_back(e);
    end
    sensor_raw = 1'b1;
    tick(hi);
    sensor_raw = 1'b0;
  endtask

  // Monitor: any strobe pops one expected record and compares every field.
  always @(negedge clk50M) begin
    exp_t e;
    if (reset_n && (blip_pulse || period_valid)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: cycle %0d blip=%0b pv=%0b period=%0d ped=%0b, none expected",
                 cyc, blip_pulse, period_valid, period_out, pedaling);
      end else begin
        e = q.pop_front();
        chk("evt_cycle",    cyc,          e.cyc);
        chk("blip_pulse",   blip_pulse,   e.blip);
        chk("period_valid", period_valid, e.pv);
        chk("period_out",   period_out,   e.per);
        chk("pedaling",     pedaling,     e.ped);
        chk("glitch_cnt",   glitch_cnt,   e.g);
      end
    end
    if (!reset_n) begin
      run = 0;
    end else if (blips_out) begin
      run = run + 1;
    end else if (run > 0) begin
      chk("blips_out_width", run, PULSE);
      run = 0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t e;

    tick(5);
    check_zero("reset");
    reset_n = 1'b1;
    tick(10);

    // 1: first edge from idle, then 300-cycle cadence.
    rise(50, 1, 0, 0,   1, 0, n); tick(250);
    rise(50, 1, 1, 300, 1, 0, n); tick(250);
    rise(50, 1, 1, 300, 1, 0, n); tick(250);

    // 2: bounce for 30 cycles, then a clean rise 330 after the last edge.
    for (int i = 0; i < 10; i++) begin
      sensor_raw = (i % 2 == 0);
      tick(3);
    end
    rise(50, 1, 1, 330, 1, 0, n); tick(250);

    // 3: too-fast edge rejected, next one 120 after the last accepted.
    rise(20, 1, 1, 300, 1, 0, n); tick(40);
    rise(20, 0, 0, 0,   0, 0, n); tick(40);
    chk("glitch_after_reject", glitch_cnt, 1);
    rise(50, 1, 1, 120, 1, 1, n);

    // 4: timeout 1001 cycles after the accepted blip, then restart from idle.
    e = '{cyc: n + LAT + 1001, blip: 1'b0, pv: 1'b1, per: 0, ped: 1'b0, g: 1};
    q.push_back(e);
    tick(1050);
    rise(50, 1, 0, 0, 1, 1, n); tick(951);

    // 6: edge coinciding with saturation, then an edge exactly 1000 apart.
    rise(50, 1, 1, 1000, 1, 1, n); tick(950);
    rise(50, 1, 1, 1000, 1, 1, n); tick(250);

    // 5: reset during the stretched blip.
    rise(12, 1, 1, 300, 1, 1, n);
    #2 reset_n = 1'b0;
    #1 check_zero("rst_mid_pulse");
    tick(3);
    reset_n = 1'b1;
    tick(20);

    // 5: reset mid-debounce with the sensor held high through release.
    sensor_raw = 1'b1;
    tick(6);
    #2 reset_n = 1'b0;
    #1 check_zero("rst_mid_debounce");
    tick(2);
    reset_n = 1'b1;
    e = '{cyc: cyc + LAT, blip: 1'b1, pv: 1'b0, per: 0, ped: 1'b1, g: 0};
    q.push_back(e);
    tick(40);
    sensor_raw = 1'b0;
    tick(50);

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
